// File: rtl/lpddr_cfg_apb_stub.sv
// ----------------------------------------------------------------------------
// lpddr_cfg_apb_stub
//
// APB4 configuration slave for the LPDDR partition DV stub. It stands in for
// the tied-off cfg APB port and sits between the NoC cfg APB fence and the
// fake memory model, clocked on the LPDDR clock.
//
// Contents:
//   - Register file addressed by paddr[log2(NUM_REGS)+1:2]:
//       0 CTRL     bit0 START (self-clearing), bit1 INJ_FAIL (RW),
//                  bit2 CLR (write-1 pulse)
//       1 STATUS   RO: bit0 busy, bit1 init_cmplt, bit2 trng_cmplt,
//                  bit3 trng_fail
//       2 TRNG_CNT RO: remaining training cycles
//       3..        scratch, byte-masked by pstrb
//   - Programmable wait states before pready.
//   - PSLVERR for out-of-range or misaligned addresses.
//   - PHY training emulation: START launches a TRNG_CYCLES countdown that ends
//     in init-complete or training-fail, with registered level interrupts.
//
// Ports:
//   i_clk, i_rst_n           LPDDR clock, asynchronous active-low reset
//   i_paddr .. i_pprot       APB4 requester signals (i_pprot ignored)
//   o_prdata, o_pready,
//   o_pslverr                APB4 completer signals
//   o_phy_*_intr             level interrupts mirroring STATUS[3:1]
//   o_busy                   training in progress
// ----------------------------------------------------------------------------
module lpddr_cfg_apb_stub #(
  parameter int NUM_REGS    = 64,   // power of two, >= 4
  parameter int WAIT_STATES = 1,    // 0..15
  parameter int TRNG_CYCLES = 1000, // >= 1
  parameter int CNT_W       = 16    // TRNG_CYCLES < 2**CNT_W, CNT_W <= 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_paddr,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [31:0] i_pwdata,
  input  logic [3:0]  i_pstrb,
  input  logic [2:0]  i_pprot,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_pslverr,
  output logic        o_phy_init_cmplt_intr,
  output logic        o_phy_trng_cmplt_intr,
  output logic        o_phy_trng_fail_intr,
  output logic        o_busy
);

  localparam int               IDX_W      = $clog2(NUM_REGS);
  localparam logic [31:0]      ADDR_LIMIT = 32'(NUM_REGS * 4);
  localparam logic [3:0]       WS         = 4'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(TRNG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } trng_state_e;

  // APB protection attributes carry no meaning for this stub.
  logic w_unused_pprot;
  assign w_unused_pprot = ^i_pprot;

  // --------------------------------------------------------------------------
  // APB transfer FSM
  // --------------------------------------------------------------------------
  apb_state_e r_apb_state;
  apb_state_e w_apb_state_nxt;
  logic [3:0] r_wcnt;
  logic       w_pready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_apb_state <= ST_IDLE;
    end else begin
      r_apb_state <= w_apb_state_nxt;
    end
  end

  always_comb begin
    w_apb_state_nxt = r_apb_state;
    case (r_apb_state)
      ST_IDLE: begin
        if (i_psel && !i_penable) w_apb_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_apb_state_nxt = i_psel ? ST_ACCESS : ST_IDLE;
      end
      ST_ACCESS: begin
        // A requester that drops penable while keeping psel has started a
        // new setup phase, so re-enter SETUP instead of idling.
        if (!i_psel)             w_apb_state_nxt = ST_IDLE;
        else if (!i_penable)     w_apb_state_nxt = ST_SETUP;
        else if (w_pready)       w_apb_state_nxt = ST_IDLE;
      end
      default: w_apb_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pready = (r_apb_state == ST_ACCESS) && (r_wcnt == WS);
  end

  // Wait counter: cleared on entry to SETUP, counts stalled ACCESS cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wcnt <= '0;
    end else if (w_apb_state_nxt == ST_SETUP) begin
      r_wcnt <= '0;
    end else if ((r_apb_state == ST_ACCESS) && !w_pready) begin
      r_wcnt <= r_wcnt + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Address decode and transfer qualification
  // --------------------------------------------------------------------------
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic             w_xfer_done;
  logic             w_wr_commit;
  logic             w_rd_valid;
  logic             w_ctrl_wr;
  logic             w_start;
  logic             w_clr;

  assign w_err       = (i_paddr >= ADDR_LIMIT) || (i_paddr[1:0] != 2'b00);
  assign w_idx       = i_paddr[IDX_W+1:2];
  assign w_xfer_done = i_psel && i_penable && w_pready;
  assign w_wr_commit = w_xfer_done && i_pwrite && !w_err;
  assign w_rd_valid  = w_xfer_done && !i_pwrite && !w_err;

  // CTRL fields all live in byte 0, so they follow pstrb[0].
  assign w_ctrl_wr = w_wr_commit && (w_idx == IDX_W'(0)) && i_pstrb[0];
  assign w_start   = w_ctrl_wr && i_pwdata[0];
  assign w_clr     = w_ctrl_wr && i_pwdata[2];

  assign o_pready  = w_pready;
  assign o_pslverr = w_pready && w_err;

  // --------------------------------------------------------------------------
  // CTRL.INJ_FAIL and scratch registers
  // --------------------------------------------------------------------------
  logic        r_inj_fail;
  logic [31:0] r_scratch [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inj_fail <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_inj_fail <= i_pwdata[1];
    end
  end

  // Entries 0..2 are never written; they exist only to keep the index simple.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_scratch[i] <= '0;
      end
    end else if (w_wr_commit && (w_idx >= IDX_W'(3))) begin
      for (int b = 0; b < 4; b++) begin
        if (i_pstrb[b]) r_scratch[w_idx][8*b +: 8] <= i_pwdata[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Training FSM
  // --------------------------------------------------------------------------
  trng_state_e      r_trng_state;
  trng_state_e      w_trng_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_init_cmplt;
  logic             r_trng_cmplt;
  logic             r_trng_fail;
  logic             w_busy;
  logic             w_trng_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trng_state <= T_IDLE;
    end else begin
      r_trng_state <= w_trng_state_nxt;
    end
  end

  always_comb begin
    w_trng_state_nxt = r_trng_state;
    case (r_trng_state)
      T_IDLE, T_DONE: begin
        if (w_start) w_trng_state_nxt = T_RUN;
      end
      T_RUN: begin
        if (r_cnt == '0) w_trng_state_nxt = T_DONE;
      end
      default: w_trng_state_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_trng_state == T_RUN);
    w_trng_done = (r_trng_state == T_RUN) && (r_cnt == '0);
  end

  // Completion takes priority over a coincident CLR; START cannot coincide
  // with completion because it is ignored while running. INJ_FAIL is looked
  // at only here, so it may be changed while a run is in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_init_cmplt <= 1'b0;
      r_trng_cmplt <= 1'b0;
      r_trng_fail  <= 1'b0;
    end else if (w_trng_done) begin
      r_trng_cmplt <= 1'b1;
      r_trng_fail  <= r_inj_fail;
      r_init_cmplt <= !r_inj_fail;
    end else if (w_start && !w_busy) begin
      r_cnt        <= CNT_LOAD;
      r_init_cmplt <= 1'b0;
      r_trng_cmplt <= 1'b0;
      r_trng_fail  <= 1'b0;
    end else begin
      if (w_clr) begin
        r_init_cmplt <= 1'b0;
        r_trng_cmplt <= 1'b0;
        r_trng_fail  <= 1'b0;
      end
      if (w_busy) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt outputs: registered copies of STATUS[3:1]
  // --------------------------------------------------------------------------
  logic r_init_intr;
  logic r_trng_intr;
  logic r_fail_intr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init_intr <= 1'b0;
      r_trng_intr <= 1'b0;
      r_fail_intr <= 1'b0;
    end else begin
      r_init_intr <= r_init_cmplt;
      r_trng_intr <= r_trng_cmplt;
      r_fail_intr <= r_trng_fail;
    end
  end

  assign o_phy_init_cmplt_intr = r_init_intr;
  assign o_phy_trng_cmplt_intr = r_trng_intr;
  assign o_phy_trng_fail_intr  = r_fail_intr;
  assign o_busy                = w_busy;

  // --------------------------------------------------------------------------
  // Read data: driven only in the pready cycle of a legal read
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      IDX_W'(0): w_rdata = {29'd0, 1'b0, r_inj_fail, 1'b0};
      IDX_W'(1): w_rdata = {28'd0, r_trng_fail, r_trng_cmplt, r_init_cmplt, w_busy};
      IDX_W'(2): w_rdata = 32'(r_cnt);
      default:   w_rdata = r_scratch[w_idx];
    endcase
  end

  assign o_prdata = w_rd_valid ? w_rdata : 32'd0;

endmodule

// File: doc/lpddr_cfg_apb_stub.md
Name: lpddr_cfg_apb_stub

Overview:
- Parametrised APB4 configuration-slave stub for the LPDDR partition DV stub. It replaces the tied-off cfg APB port, which hangs any access because pready is held low.
- Provides a scratch register file with programmable wait states and error responses for illegal addresses.
- Emulates PHY training: a software start bit launches a countdown, which then raises init-complete, training-complete or training-fail interrupts.
- Sits between the NoC cfg APB fence and the fake memory model; clocked on the LPDDR clock.

Parameters:
NUM_REGS, 64, number of 32-bit registers; power of two, minimum 4
WAIT_STATES, 1, access-phase cycles before pready (0..15)
TRNG_CYCLES, 1000, training duration in clocks after start (>=1)
CNT_W, 16, width of the training counter; TRNG_CYCLES must be < 2**CNT_W

Ports:
i_clk  in  1  LPDDR clock
i_rst_n  in  1  asynchronous active-low reset
i_paddr  in  32  APB address, byte-addressed
i_psel  in  1  APB select
i_penable  in  1  APB enable
i_pwrite  in  1  APB write
i_pwdata  in  32  APB write data
i_pstrb  in  4  APB byte strobes
i_pprot  in  3  APB protection; ignored
o_prdata  out  32  APB read data
o_pready  out  1  APB ready
o_pslverr  out  1  APB error
o_phy_init_cmplt_intr  out  1  level; STATUS[1]
o_phy_trng_cmplt_intr  out  1  level; STATUS[2]
o_phy_trng_fail_intr  out  1  level; STATUS[3]
o_busy  out  1  training in progress

Behaviour:
- Reset: i_rst_n is asynchronous, active-low. While it is asserted, all registers, FSMs and counters clear to 0, and every output is 0.
- Register map (word index = paddr[log2(NUM_REGS)+1:2]):
  - 0 CTRL: bit0 START (self-clearing, reads 0); bit1 INJ_FAIL (RW); bit2 CLR (write-1 pulse, reads 0).
  - 1 STATUS (RO): bit0 busy, bit1 init_cmplt, bit2 trng_cmplt, bit3 trng_fail.
  - 2 TRNG_CNT (RO): remaining training cycles, zero-extended.
  - 3..NUM_REGS-1: scratch RW, byte-masked by pstrb.
- Writes to RO registers are dropped without error.
- APB FSM states: IDLE, SETUP, ACCESS.
  - psel & !penable → SETUP; the wait counter loads 0.
  - In ACCESS, o_pready = (wcnt == WAIT_STATES), combinational from wcnt. wcnt increments each ACCESS cycle while pready is low.
  - WAIT_STATES=0 gives pready in the first ACCESS cycle.
  - o_pready is 0 outside ACCESS.
  - Back-to-back transfers (psel held, penable dropped) re-enter SETUP.
- Error conditions: paddr >= NUM_REGS*4, or paddr[1:0] != 0.
  - o_pslverr=1 only in the pready cycle.
  - The write is discarded and o_prdata=0.
- Write commit: only in the cycle psel & penable & pready & pwrite & !err. o_prdata is valid in the read's pready cycle and 0 otherwise.
- Training FSM states: T_IDLE, T_RUN, T_DONE.
  - T_IDLE/T_DONE + committed CTRL write with START=1 → T_RUN. Counter loads TRNG_CYCLES-1; STATUS[3:1] clear; busy=1.
  - T_RUN: counter decrements each cycle. At 0, go to T_DONE next cycle: busy=0, trng_cmplt=1, and either trng_fail=1 (INJ_FAIL=1) or init_cmplt=1 (INJ_FAIL=0).
  - INJ_FAIL is sampled at completion, not at start.
  - START while in T_RUN is ignored; the counter is not reloaded.
  - CLR clears STATUS[3:1] in any state and does not abort T_RUN.
  - CLR and START in the same write: clear is applied, then the run starts. The net effect equals START alone.
  - A completion cycle coinciding with a CLR write: completion wins, and the status bits set.
- Interrupt outputs are registered copies of the status bits: one-cycle latency from a status change, sticky until CLR or START.
- Reset mid-transfer: pready and pslverr drop to 0 immediately. Scratch and status contents are lost. The training counter returns to 0.

Test Plan:
- Reset release, read idx 5 (0x14) with WAIT_STATES=1 → pready in the 2nd ACCESS cycle, prdata=0, pslverr=0.
- Write 0xA5A5_1234 to 0x10 with pstrb=4'b0101, then read → 0x00A5_0034.
- Read 0x100 (NUM_REGS=64), then write 0x102 → both pslverr=1, prdata=0; scratch contents unchanged.
- Write CTRL=0x1, TRNG_CYCLES=8 → o_busy high for 8 cycles. Then STATUS=0x6; init_cmplt and trng_cmplt interrupts rise the following cycle.
- Set INJ_FAIL, START; write START again mid-run; then CLR → completion at the original time with STATUS=0xC; after CLR, STATUS=0x0 and all interrupts low.
- Assert i_rst_n low mid-run at count 3 → o_busy=0, o_pready=0 asynchronously; TRNG_CNT reads 0 after release.
